// File: rtl/sparse_weight_packer_if.sv
// sparse_weight_packer_if: dense-group input and packed-group output valid/ready bus
interface sparse_weight_packer_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] dense_weights;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     mask;
    logic [W-1:0]   weight_top;
    logic [W-1:0]   weight_bot;
    logic           out_lossy;
    modport master (
        output in_valid, dense_weights, out_ready,
        input  in_ready, out_valid, mask, weight_top, weight_bot, out_lossy
    );
    modport slave (
        input  in_valid, dense_weights, out_ready,
        output in_ready, out_valid, mask, weight_top, weight_bot, out_lossy
    );
endinterface

// File: rtl/sparse_weight_packer.sv
// sparse_weight_packer: 2:4 structured-sparsity compressor, two-stage valid/ready pipeline.
// Define SPARSE_PACK_STATS_EN to add saturating group/lossy counters.
module sparse_weight_packer #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    sparse_weight_packer_if.slave bus
`ifdef SPARSE_PACK_STATS_EN
    ,
    output logic [31:0]          stat_groups,
    output logic [31:0]          stat_lossy
`endif
);
    logic [W-1:0] w [4];
    logic [2:0]   beat [4];
    logic [2:0]   nz;
    logic [3:0]   sel_mask;
    logic [W-1:0] sel_top;
    logic [W-1:0] sel_bot;
    logic         sel_lossy;
    logic         s1_valid;
    logic [3:0]   s1_mask;
    logic [W-1:0] s1_top;
    logic [W-1:0] s1_bot;
    logic         s1_lossy;
    logic         s2_load;
    logic         in_fire;

    // rank each weight by how many others beat it (larger, or equal at a lower index); keep the top two
    always_comb begin
        nz = '0;
        sel_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w[i] = bus.dense_weights[i*W +: W];
            nz = nz + {2'b00, w[i] != '0};
        end
        for (int i = 0; i < 4; i++) begin
            beat[i] = '0;
            for (int j = 0; j < 4; j++)
                if (j != i && (w[j] > w[i] || (w[j] == w[i] && j < i)))
                    beat[i] = beat[i] + 3'd1;
            sel_mask[i] = beat[i] < 3'd2;
        end
        sel_bot   = sel_mask[0] ? w[0] : sel_mask[1] ? w[1] : w[2];
        sel_top   = sel_mask[3] ? w[3] : sel_mask[2] ? w[2] : w[1];
        sel_lossy = nz > 3'd2;
    end

    assign s2_load      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = rst_n && !clr && (!s1_valid || s2_load);
    assign in_fire      = bus.in_valid && bus.in_ready;

    // stage 1: capture the selection on accept, empty out when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            s1_valid <= 1'b0;
            s1_mask  <= '0;
            s1_top   <= '0;
            s1_bot   <= '0;
            s1_lossy <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_mask  <= sel_mask;
            s1_top   <= sel_top;
            s1_bot   <= sel_bot;
            s1_lossy <= sel_lossy;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            bus.out_valid  <= 1'b0;
            bus.mask       <= '0;
            bus.weight_top <= '0;
            bus.weight_bot <= '0;
            bus.out_lossy  <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.mask       <= s1_mask;
                bus.weight_top <= s1_top;
                bus.weight_bot <= s1_bot;
                bus.out_lossy  <= s1_lossy;
            end
        end
    end

`ifdef SPARSE_PACK_STATS_EN
    // saturating counts of delivered groups and of lossy ones among them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            stat_groups <= '0;
            stat_lossy  <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (stat_groups != '1) stat_groups <= stat_groups + 32'd1;
            if (bus.out_lossy && stat_lossy != '1) stat_lossy <= stat_lossy + 32'd1;
        end
    end
`endif
endmodule
